// File: rtl/rtl_settings_pkg.sv
// rtl/rtl_settings_pkg.sv - shared AMM geometry, compare command type and address helper
package rtl_settings_pkg;

    localparam int    ADDR_W      = 32;
    localparam int    DATA_W      = 32;
    localparam int    DATA_B_W    = DATA_W / 8;
    localparam int    ADDR_B_W    = $clog2(DATA_B_W);
    localparam int    AMM_BURST_W = 8;
    localparam string ADDR_TYPE   = "BYTE";

    typedef enum logic [1:0] {
        MODE_FIXED,
        MODE_INCR,
        MODE_RANDOM
    } data_mode_t;

    typedef struct packed {
        logic [ADDR_W-1:0]      start_addr;
        logic [AMM_BURST_W-1:0] words_count;
        logic [ADDR_B_W-1:0]    start_off;
        logic [ADDR_B_W-1:0]    end_off;
        logic [7:0]             data_ptrn;
        data_mode_t             data_mode;
    } cmp_struct_t;

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } rd_state_t;

    // Byte-addressed slaves expect word-aligned burst starts.
    function automatic logic [ADDR_W-1:0] amm_word_addr(input logic [ADDR_W-1:0] addr);
        if (ADDR_TYPE == "BYTE")
            return {addr[ADDR_W-1:ADDR_B_W], {ADDR_B_W{1'b0}}};
        else
            return addr;
    endfunction

endpackage

// File: rtl/fifo.sv
// rtl/fifo.sv - show-ahead synchronous FIFO, depth 2**AWIDTH, with synchronous clear
module fifo #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              wrreq_i,
    input  logic              rdreq_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              empty_o
);

    localparam int DEPTH = 2 ** AWIDTH;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AWIDTH-1:0] wr_ptr_q;
    logic [AWIDTH-1:0] rd_ptr_q;
    logic [AWIDTH:0]   cnt_q;
    logic              full;
    logic              do_wr;
    logic              do_rd;

    assign full    = (cnt_q == (AWIDTH+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_wr   = wrreq_i && !full;
    assign do_rd   = rdreq_i && !empty_o;
    assign q_o     = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (do_wr)
            mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (srst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_wr)
                wr_ptr_q <= wr_ptr_q + AWIDTH'(1);
            if (do_rd)
                rd_ptr_q <= rd_ptr_q + AWIDTH'(1);
            if (do_wr && !do_rd)
                cnt_q <= cnt_q + (AWIDTH+1)'(1);
            else if (do_rd && !do_wr)
                cnt_q <= cnt_q - (AWIDTH+1)'(1);
        end
    end

endmodule

// File: rtl/read_request_block.sv
// rtl/read_request_block.sv - issues AMM read bursts and tracks outstanding bursts by returned beats
module read_request_block
    import rtl_settings_pkg::*;
#(
    parameter int MAX_OUTST = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_test_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  cmp_struct_t            cmd_struct_i,
    output logic [ADDR_W-1:0]      address_o,
    output logic                   read_o,
    output logic [AMM_BURST_W-1:0] burstcount_o,
    output logic [DATA_B_W-1:0]    byteenable_o,
    input  logic                   waitrequest_i,
    input  logic                   readdatavalid_i,
    output logic                   cmp_en_o,
    output cmp_struct_t            cmp_struct_o,
    output logic                   rd_busy_o
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam int Q_AW  = $clog2(MAX_OUTST);

    rd_state_t              state_q, state_d;
    cmp_struct_t            cmd_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [AMM_BURST_W-1:0] burst_q;
    logic [CNT_W-1:0]       outst_q, outst_d;
    logic [AMM_BURST_W-1:0] beat_q, beat_d;
    logic                   busy_q;

    logic                   cmd_acc;
    logic                   amm_acc;
    logic                   rdv_ok;
    logic                   last_beat;
    logic [AMM_BURST_W-1:0] head_len;
    logic                   len_empty;

    assign cmd_ready_o  = (state_q == ST_IDLE) && (outst_q < CNT_W'(MAX_OUTST));
    assign cmd_acc      = cmd_valid_i && cmd_ready_o;
    assign read_o       = (state_q == ST_REQ);
    assign amm_acc      = read_o && !waitrequest_i;
    assign cmp_en_o     = amm_acc;
    assign cmp_struct_o = cmd_q;
    assign address_o    = addr_q;
    assign burstcount_o = burst_q;
    assign byteenable_o = '1;
    assign rd_busy_o    = busy_q;

    // Beats arriving with nothing queued are stray and must not advance tracking.
    assign rdv_ok    = readdatavalid_i && !len_empty;
    assign last_beat = rdv_ok && ((beat_q + AMM_BURST_W'(1)) == head_len);

    fifo #(
        .DWIDTH (AMM_BURST_W),
        .AWIDTH (Q_AW)
    ) u_len_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .srst_i  (start_test_i),
        .data_i  (burst_q),
        .wrreq_i (amm_acc),
        .rdreq_i (last_beat),
        .q_o     (head_len),
        .empty_o (len_empty)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_acc) state_d = ST_REQ;
            ST_REQ:  if (!waitrequest_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (start_test_i)
            state_d = ST_IDLE;
    end

    always_comb begin
        beat_d  = beat_q;
        outst_d = outst_q;
        if (rdv_ok)
            beat_d = last_beat ? '0 : beat_q + AMM_BURST_W'(1);
        case ({amm_acc, last_beat})
            2'b10:   outst_d = outst_q + CNT_W'(1);
            2'b01:   outst_d = outst_q - CNT_W'(1);
            default: outst_d = outst_q;
        endcase
        if (start_test_i) begin
            beat_d  = '0;
            outst_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            outst_q <= '0;
            beat_q  <= '0;
            busy_q  <= 1'b0;
            cmd_q   <= '0;
            addr_q  <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            outst_q <= outst_d;
            beat_q  <= beat_d;
            busy_q  <= (state_d == ST_REQ) || (outst_d != '0);
            if (cmd_acc) begin
                cmd_q   <= cmd_struct_i;
                addr_q  <= amm_word_addr(cmd_struct_i.start_addr);
                burst_q <= cmd_struct_i.words_count + AMM_BURST_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_read_request_block.sv
// tb/tb_read_request_block.sv - directed and random checks of read_request_block against a queue model
module tb_read_request_block;
    import rtl_settings_pkg::*;

    localparam int MAX_OUTST = 4;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic                   start_test_i;
    logic                   cmd_valid_i;
    logic                   cmd_ready_o;
    cmp_struct_t            cmd_struct_i;
    logic [ADDR_W-1:0]      address_o;
    logic                   read_o;
    logic [AMM_BURST_W-1:0] burstcount_o;
    logic [DATA_B_W-1:0]    byteenable_o;
    logic                   waitrequest_i;
    logic                   readdatavalid_i;
    logic                   cmp_en_o;
    cmp_struct_t            cmp_struct_o;
    logic                   rd_busy_o;

    read_request_block #(.MAX_OUTST(MAX_OUTST)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_test_i    (start_test_i),
        .cmd_valid_i     (cmd_valid_i),
        .cmd_ready_o     (cmd_ready_o),
        .cmd_struct_i    (cmd_struct_i),
        .address_o       (address_o),
        .read_o          (read_o),
        .burstcount_o    (burstcount_o),
        .byteenable_o    (byteenable_o),
        .waitrequest_i   (waitrequest_i),
        .readdatavalid_i (readdatavalid_i),
        .cmp_en_o        (cmp_en_o),
        .cmp_struct_o    (cmp_struct_o),
        .rd_busy_o       (rd_busy_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int acc_seen  = 0;
    int push_seen = 0;

    // Model: each outstanding burst is just its count of beats still owed.
    int          q[$];
    bit          m_req;
    bit          m_busy;
    logic [31:0] m_addr;
    int          m_burst;
    cmp_struct_t m_cmd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_req  = 1'b0;
        m_busy = 1'b0;
    endtask

    task automatic set_cmd(input logic [31:0] addr, input int wc);
        cmd_struct_i.start_addr  = addr;
        cmd_struct_i.words_count = 8'(wc);
        cmd_struct_i.start_off   = 2'($urandom_range(0, 3));
        cmd_struct_i.end_off     = 2'($urandom_range(0, 3));
        cmd_struct_i.data_ptrn   = 8'($urandom);
        cmd_struct_i.data_mode   = data_mode_t'($urandom_range(0, 2));
    endtask

    task automatic step();
        bit exp_ready;
        bit exp_cmp;
        #4;
        exp_ready = !m_req && (q.size() < MAX_OUTST);
        exp_cmp   = m_req && !waitrequest_i;
        chk("cmd_ready", 64'(cmd_ready_o), 64'(exp_ready));
        chk("read", 64'(read_o), 64'(m_req));
        chk("cmp_en", 64'(cmp_en_o), 64'(exp_cmp));
        chk("rd_busy", 64'(rd_busy_o), 64'(m_busy));
        if (m_req) begin
            chk("address", 64'(address_o), 64'(m_addr));
            chk("burstcount", 64'(burstcount_o), 64'(m_burst));
            chk("byteenable", 64'(byteenable_o), 64'((1 << DATA_B_W) - 1));
        end
        if (exp_cmp)
            chk("cmp_struct", 64'(cmp_struct_o), 64'(m_cmd));
        if (cmd_valid_i && cmd_ready_o) acc_seen++;
        if (cmp_en_o) push_seen++;
        if (start_test_i) begin
            model_reset();
        end else begin
            if (readdatavalid_i && q.size() > 0) begin
                q[0] = q[0] - 1;
                if (q[0] == 0) void'(q.pop_front());
            end
            if (exp_cmp) begin
                q.push_back(m_burst);
                m_req = 1'b0;
            end
            if (cmd_valid_i && exp_ready) begin
                m_req   = 1'b1;
                m_cmd   = cmd_struct_i;
                m_addr  = cmd_struct_i.start_addr - (cmd_struct_i.start_addr % DATA_B_W);
                m_burst = (int'(cmd_struct_i.words_count) + 1) % (1 << AMM_BURST_W);
            end
            m_busy = m_req || (q.size() != 0);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain(input int n);
        cmd_valid_i     = 1'b0;
        waitrequest_i   = 1'b0;
        readdatavalid_i = 1'b1;
        repeat (n) step();
        readdatavalid_i = 1'b0;
    endtask

    initial begin
        int acc0;
        int push0;
        rst_i           = 1'b1;
        start_test_i    = 1'b0;
        cmd_valid_i     = 1'b0;
        waitrequest_i   = 1'b0;
        readdatavalid_i = 1'b0;
        cmd_struct_i    = '0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ready", 64'(cmd_ready_o), 64'd1);
        chk("rst_read", 64'(read_o), 64'd0);
        chk("rst_cmp_en", 64'(cmp_en_o), 64'd0);
        chk("rst_busy", 64'(rd_busy_o), 64'd0);
        chk("rst_address", 64'(address_o), 64'd0);
        chk("rst_burst", 64'(burstcount_o), 64'd0);
        chk("rst_byteen", 64'(byteenable_o), 64'hF);
        rst_i = 1'b0;

        // Single 4-beat burst, no stall
        set_cmd(32'h100, 3);
        cmd_valid_i = 1'b1;
        step();
        cmd_valid_i = 1'b0;
        chk("busy_after_accept", 64'(rd_busy_o), 64'd1);
        chk("addr_0x100", 64'(address_o), 64'h100);
        chk("burst_4", 64'(burstcount_o), 64'd4);
        step();
        repeat (2) step();
        readdatavalid_i = 1'b1;
        repeat (4) step();
        readdatavalid_i = 1'b0;
        chk("busy_low_after_last", 64'(rd_busy_o), 64'd0);

        // Five-cycle stall holds request stable with exactly one push
        set_cmd($urandom, 2);
        cmd_valid_i = 1'b1;
        step();
        cmd_valid_i   = 1'b0;
        push0         = push_seen;
        waitrequest_i = 1'b1;
        repeat (5) step();
        chk("no_push_while_stalled", 64'(push_seen - push0), 64'd0);
        waitrequest_i = 1'b0;
        step();
        chk("one_push_after_stall", 64'(push_seen - push0), 64'd1);
        drain(3);

        // Back-to-back one-beat commands saturate the outstanding limit
        acc0 = acc_seen;
        set_cmd($urandom, 0);
        cmd_valid_i = 1'b1;
        repeat (10) step();
        chk("accepts_at_limit", 64'(acc_seen - acc0), 64'd4);
        chk("ready_low_at_limit", 64'(cmd_ready_o), 64'd0);
        readdatavalid_i = 1'b1;
        step();
        readdatavalid_i = 1'b0;
        step();
        step();
        cmd_valid_i = 1'b0;
        chk("fifth_accepted", 64'(acc_seen - acc0), 64'd5);
        drain(4);

        // Oldest burst finishes on the same cycle a new burst is accepted
        cmd_valid_i = 1'b1;
        set_cmd($urandom, 0);
        step();
        step();
        set_cmd($urandom, 1);
        step();
        step();
        set_cmd($urandom, 0);
        step();
        cmd_valid_i     = 1'b0;
        readdatavalid_i = 1'b1;
        step();
        readdatavalid_i = 1'b0;
        cmd_valid_i     = 1'b1;
        repeat (4) step();
        chk("coincide_keeps_two", 64'(cmd_ready_o), 64'd0);
        cmd_valid_i = 1'b0;
        drain(5);

        // Byte address alignment
        set_cmd(32'h10B, 0);
        cmd_valid_i = 1'b1;
        step();
        cmd_valid_i = 1'b0;
        chk("addr_aligned", 64'(address_o), 64'h108);
        step();
        drain(1);

        start_test_i = 1'b1;
        step();
        start_test_i = 1'b0;
        chk("start_test_ready", 64'(cmd_ready_o), 64'd1);
        chk("start_test_busy", 64'(rd_busy_o), 64'd0);

        for (int i = 0; i < 400; i++) begin
            set_cmd($urandom, $urandom_range(0, 7));
            cmd_valid_i     = 1'($urandom_range(0, 1));
            waitrequest_i   = ($urandom_range(0, 3) == 0);
            readdatavalid_i = 1'($urandom_range(0, 1));
            step();
        end
        step();
        drain(40);
        chk("drained_idle", 64'(rd_busy_o), 64'd0);

        // Asynchronous reset in the middle of a stalled request
        set_cmd($urandom, 5);
        cmd_valid_i = 1'b1;
        step();
        cmd_valid_i   = 1'b0;
        waitrequest_i = 1'b1;
        #2;
        rst_i = 1'b1;
        #1;
        chk("midreq_rst_read", 64'(read_o), 64'd0);
        chk("midreq_rst_busy", 64'(rd_busy_o), 64'd0);
        chk("midreq_rst_ready", 64'(cmd_ready_o), 64'd1);
        chk("midreq_rst_cmp_en", 64'(cmp_en_o), 64'd0);
        @(posedge clk_i);
        #1;
        rst_i         = 1'b0;
        waitrequest_i = 1'b0;
        model_reset();
        cmd_valid_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            set_cmd($urandom, 0);
            step();
        end
        cmd_valid_i = 1'b0;
        drain(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/read_request_block.md
READ_REQUEST_BLOCK -- requirements
Module: read_request_block

Interface
REQ-001 SHALL have parameter MAX_OUTST, default 4, meaning maximum read bursts in flight; it SHALL match the compare storage depth.
REQ-002 SHALL have port clk_i  input  1  the single clock.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start_test_i  input  1  synchronous clear pulse at test start.
REQ-005 SHALL have port cmd_valid_i  input  1  read command valid.
REQ-006 SHALL have port cmd_ready_o  output  1  read command accepted when high together with cmd_valid_i.
REQ-007 SHALL have port cmd_struct_i  input  cmp_struct_t  read command: start_addr, words_count, start_off, end_off, data_ptrn, data_mode.
REQ-008 SHALL have port address_o  output  ADDR_W  AMM read address.
REQ-009 SHALL have port read_o  output  1  AMM read request.
REQ-010 SHALL have port burstcount_o  output  AMM_BURST_W  AMM burst length.
REQ-011 SHALL have port byteenable_o  output  DATA_B_W  AMM byteenable.
REQ-012 SHALL have port waitrequest_i  input  1  AMM stall.
REQ-013 SHALL have port readdatavalid_i  input  1  AMM read beat returned.
REQ-014 SHALL have port cmp_en_o  output  1  one-cycle push into compare storage.
REQ-015 SHALL have port cmp_struct_o  output  cmp_struct_t  command forwarded to compare stage.
REQ-016 SHALL have port rd_busy_o  output  1  request issue pending or bursts outstanding.

Function
REQ-017 SHALL implement FSM states IDLE and REQ; in IDLE, acceptance (cmd_valid_i && cmd_ready_o) registers cmd_struct_i and moves to REQ.
REQ-018 cmd_ready_o SHALL equal (state == IDLE) && (outst_cnt < MAX_OUTST), combinationally.
REQ-019 In REQ, read_o SHALL be 1 and address_o, burstcount_o, byteenable_o SHALL stay stable until a cycle with waitrequest_i = 0, then FSM returns to IDLE.
REQ-020 address_o SHALL be start_addr with low ADDR_B_W bits zeroed when ADDR_TYPE == "BYTE", start_addr unchanged when "WORD".
REQ-021 burstcount_o SHALL be words_count + 1, computed at AMM_BURST_W width; byteenable_o SHALL be all ones.
REQ-022 On the accept cycle (read_o && !waitrequest_i), cmp_en_o SHALL pulse for exactly that cycle with cmp_struct_o holding the registered command; one push per burst, never otherwise.
REQ-023 outst_cnt (0..MAX_OUTST) SHALL increment on accept, decrement when the last beat of the oldest burst returns, and stay unchanged when both coincide.
REQ-024 Burst lengths SHALL be queued at accept; a beat counter loads from the queue head and counts readdatavalid_i; at its last beat the head is popped.
REQ-025 A one-beat burst (words_count = 0) SHALL complete on its single readdatavalid_i.
REQ-026 readdatavalid_i with outst_cnt = 0 SHALL be ignored (no underflow).
REQ-027 rd_busy_o SHALL be registered, high when state == REQ or outst_cnt != 0, asserting the cycle after acceptance.
REQ-028 start_test_i SHALL synchronously return FSM to IDLE, clear outst_cnt, beat counter and length queue, and drop read_o; it is asserted only when no AMM transaction is in flight.

Reset
REQ-029 On rst_i: state IDLE, read_o 0, cmp_en_o 0, rd_busy_o 0, outst_cnt 0, queue empty, address_o/burstcount_o 0, byteenable_o all ones; cmd_ready_o then 1.

Structure
REQ-030 cmp_struct_t, ADDR_W, ADDR_B_W, ADDR_TYPE, AMM_BURST_W, DATA_B_W SHALL come from rtl_settings_pkg; MAX_OUTST stays a module parameter.
REQ-031 The length queue SHALL be one instance of existing sub-module fifo (AWIDTH = log2(MAX_OUTST)), srst_i driven by start_test_i.

Verification
REQ-032 Single command start_addr 0x100, words_count 3, waitrequest_i 0 -> read_o 1 cycle, burstcount_o 4, cmp_en_o 1 same cycle; rd_busy_o low one cycle after 4th readdatavalid_i.
REQ-033 waitrequest_i high 5 cycles -> address_o/burstcount_o stable 6 cycles, exactly one cmp_en_o pulse, on the 6th.
REQ-034 Five back-to-back commands, words_count 0, no read data -> 4 accepts, cmd_ready_o 0 with outst_cnt 4; one readdatavalid_i -> 5th accepted.
REQ-035 Last beat of oldest burst coincides with a new accept, outst_cnt 2 -> outst_cnt stays 2.
REQ-036 ADDR_TYPE "BYTE", start_addr 0x10B, DATA_B_W 4 -> address_o 0x108.
REQ-037 rst_i asserted mid-REQ -> read_o and rd_busy_o 0 immediately, outst_cnt 0, cmd_ready_o 1.
